// File: rtl/falafel_cfg_write_arbiter_if.sv
// Bundle of request, allocator-status and config-write signals for falafel_cfg_write_arbiter.
// Latency: none, this is wiring only.
// Backpressure: none here; the arbiter paces requesters with req_ready_o and the allocator with alloc_busy_i.
interface falafel_cfg_write_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    // requester side
    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_addr_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic                           req_err_o;

    // allocator side
    logic                           alloc_busy_i;
    logic                           cfg_write_o;
    logic [DATA_W-1:0]              cfg_addr_o;
    logic [DATA_W-1:0]              cfg_data_o;
    logic [ID_W-1:0]                grant_id_o;

    // environment that drives requests and allocator status
    modport master (
        output req_valid_i, req_addr_i, req_data_i, alloc_busy_i,
        input  req_ready_o, req_err_o, cfg_write_o, cfg_addr_o, cfg_data_o, grant_id_o
    );

    // the arbiter itself
    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, alloc_busy_i,
        output req_ready_o, req_err_o, cfg_write_o, cfg_addr_o, cfg_data_o, grant_id_o
    );
endinterface

// File: rtl/falafel_cfg_write_arbiter.sv
// Round-robin arbiter sharing the allocator's single config write port among NUM_REQ requesters.
// Latency: request sampled at edge 0, cfg write + ready in the cycle after edge 1; peak one write per 3 cycles.
// Backpressure: latched write waits in QUIESCE while alloc_busy_i is high; requesters hold valid until ready.
// Optional: define FALAFEL_CFG_ADDR_CHECK_EN to reject addresses outside the known map (req_err_o pulse).
// Address map used by the check: FREE_LIST_PTR_ADDR=0x10, LOCK_PTR_ADDR=0x14, LOCK_ID_ADDR=0x18.
// NUM_REQ is meant for 2..8; ID_W is derived from it.
module falafel_cfg_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    falafel_cfg_write_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_WRITE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    // latched request; r_addr/r_data double as the registered cfg_addr_o/cfg_data_o
    logic [DATA_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_rr_ptr;

    logic               w_any;
    logic               w_hi_any;
    logic [ID_W-1:0]    w_hi_id;
    logic [ID_W-1:0]    w_lo_id;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W-1:0]    w_rr_next;
    logic               w_addr_ok;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_wr;
    logic               w_err;

    // Round-robin pick: lowest pending index at or above rr_ptr, else lowest pending index overall (wrap).
    always_comb begin
        w_any    = 1'b0;
        w_hi_any = 1'b0;
        w_hi_id  = '0;
        w_lo_id  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (bus.req_valid_i[j]) begin
                w_any   = 1'b1;
                w_lo_id = ID_W'(j);
                if (ID_W'(j) >= r_rr_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_id  = ID_W'(j);
                end
            end
        end
        w_pick = w_hi_any ? w_hi_id : w_lo_id;
    end

    // The just-served requester becomes lowest priority on the next arbitration.
    assign w_rr_next = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

`ifdef FALAFEL_CFG_ADDR_CHECK_EN
    localparam logic [DATA_W-1:0] FREE_LIST_PTR_ADDR = DATA_W'(32'h10);
    localparam logic [DATA_W-1:0] LOCK_PTR_ADDR      = DATA_W'(32'h14);
    localparam logic [DATA_W-1:0] LOCK_ID_ADDR       = DATA_W'(32'h18);

    assign w_addr_ok = (r_addr == FREE_LIST_PTR_ADDR) ||
                       (r_addr == LOCK_PTR_ADDR)      ||
                       (r_addr == LOCK_ID_ADDR);
`else
    // Every address is forwarded; the config block ignores ones it does not know.
    assign w_addr_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: grab a request, wait out the allocator, then a single write cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_any) w_next_state = ST_QUIESCE;
            ST_QUIESCE: if (!bus.alloc_busy_i) w_next_state = ST_WRITE;
            ST_WRITE:   w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Request latch and round-robin pointer; later addr/data changes by the requester are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_addr <= bus.req_addr_i[w_pick];
                        r_data <= bus.req_data_i[w_pick];
                        r_id   <= w_pick;
                    end
                end
                ST_WRITE: begin
                    r_addr   <= '0;
                    r_data   <= '0;
                    r_rr_ptr <= w_rr_next;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: strobe and ready only in WRITE; a rejected address gets err instead of strobe.
    always_comb begin
        w_ready = '0;
        w_wr    = 1'b0;
        w_err   = 1'b0;
        if (r_state == ST_WRITE) begin
            w_ready[r_id] = 1'b1;
            w_wr          = w_addr_ok;
            w_err         = ~w_addr_ok;
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.req_err_o   = w_err;
    assign bus.cfg_write_o = w_wr;
    assign bus.cfg_addr_o  = r_addr;
    assign bus.cfg_data_o  = r_data;
    assign bus.grant_id_o  = r_id;

endmodule

// File: doc/falafel_cfg_write_arbiter.md
Name: falafel_cfg_write_arbiter

Overview:
- Shares the single config-register write port of the allocator among NUM_REQ requesters, e.g. host MMIO and the boot/bring-up sequencer.
- Grants one request at a time, round-robin.
- Latches address and data, then waits until the allocator is idle (alloc_busy_i low) so no config field changes mid-operation.
- Drives one write pulse on the config write port and acknowledges the winning requester in that same cycle.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of grant_id_o; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_addr_i  in  NUM_REQ x DATA_W  per-requester config address.
- req_data_i  in  NUM_REQ x DATA_W  per-requester write data.
- req_ready_o  out  NUM_REQ  per-requester one-cycle acknowledge.
- req_err_o  out  1  rejected-address pulse, coincident with req_ready_o.
- alloc_busy_i  in  1  allocator operation in progress.
- cfg_write_o  out  1  config write strobe.
- cfg_addr_o  out  DATA_W  config write address.
- cfg_data_o  out  DATA_W  config write data.
- grant_id_o  out  ID_W  index of the requester currently held.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, latched addr/data/id 0.
- FSM states: IDLE, QUIESCE, WRITE.
- IDLE:
  - If any req_valid_i is set, pick the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch its addr, data and index, then go to QUIESCE.
  - grant_id_o shows the latched index from QUIESCE onward.
- QUIESCE:
  - Stay while alloc_busy_i = 1.
  - Go to WRITE on the first edge where alloc_busy_i = 0.
- WRITE, exactly one cycle:
  - cfg_write_o = 1; cfg_addr_o and cfg_data_o carry the latched values.
  - req_ready_o[id] = 1.
  - rr_ptr <= (id + 1) mod NUM_REQ; next state IDLE.
  - alloc_busy_i is not sampled in this state.
- cfg_addr_o and cfg_data_o are registered; they hold the latched values in QUIESCE and WRITE and are 0 in IDLE. cfg_write_o is 0 outside WRITE.
- Latency with alloc_busy_i low: valid sampled at edge 0, write and ready asserted in the cycle after edge 1. Peak throughput is one write per 3 cycles.
- Handshake:
  - A requester holds valid, addr and data until it sees its ready.
  - Changes to addr/data after the latch edge are ignored.
  - Dropping valid before ready is a protocol error; the latched write still completes.
- Same requester re-requests immediately: it is ranked last behind other pending requesters.
- Reset asserted in any state:
  - Immediately returns to IDLE with all outputs 0.
  - The pending write is discarded and no ready is issued, so the requester retries after reset.
- A write to any address is passed to the config block unchanged; unknown addresses have no effect there.

Optional Feature:
FALAFEL_CFG_ADDR_CHECK_EN
- Defined:
  - In WRITE, if the latched address is not FREE_LIST_PTR_ADDR, LOCK_PTR_ADDR or LOCK_ID_ADDR, then cfg_write_o stays 0 and req_err_o = 1 together with req_ready_o[id].
  - rr_ptr advances as normal.
- Undefined: req_err_o is tied 0 and all addresses are forwarded.

Test Plan:
1. req_valid_i=01, addr FREE_LIST_PTR_ADDR, data 0x1000, busy 0 -> cfg_write_o=1 for exactly one cycle, 2 cycles after valid, with addr/data matching; req_ready_o=01 in the same cycle; grant_id_o=0.
2. After reset, req_valid_i=11 held, addr LOCK_PTR_ADDR/LOCK_ID_ADDR, data 0xA0/0x7 -> req0's write first, then req1's; grant_id_o 0 then 1; each ready pulses once.
3. req0 valid with alloc_busy_i=1 for 5 cycles -> no cfg_write_o while busy; write appears one cycle after the first low sample of busy.
4. Both requesters held valid for 8 writes -> grant_id_o alternates 0,1,0,1,...; neither requester is starved.
5. rst_ni driven low during QUIESCE -> outputs go to 0 immediately, no write and no ready. After release with req1 still valid -> req1 is granted and its write completes.
6. With FALAFEL_CFG_ADDR_CHECK_EN, addr 0xDEAD -> req_ready_o and req_err_o pulse together, cfg_write_o stays 0. Without the macro -> cfg_write_o pulses with addr 0xDEAD and req_err_o stays 0.
